// File: rtl/exp_pkg.sv
// Shared types and constants for the exception request arbiter.
package exp_pkg;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } exp_state_e;

  localparam logic [1:0] EXP_NONE = 2'd0;
  localparam logic [1:0] EXP_SRC0 = 2'd1;
  localparam logic [1:0] EXP_SRC1 = 2'd2;
  localparam logic [1:0] EXP_SRC2 = 2'd3;

  // Fixed priority: src2 beats src1 beats src0.
  function automatic logic [1:0] prio_code(input logic [NUM_SRC-1:0] elig);
    logic [1:0] code;
    if (elig[2]) begin
      code = EXP_SRC2;
    end else if (elig[1]) begin
      code = EXP_SRC1;
    end else if (elig[0]) begin
      code = EXP_SRC0;
    end else begin
      code = EXP_NONE;
    end
    return code;
  endfunction

  // One-hot source mask for an exception code (zero for EXP_NONE).
  function automatic logic [NUM_SRC-1:0] code_onehot(input logic [1:0] code);
    logic [NUM_SRC-1:0] oh;
    case (code)
      EXP_SRC0: oh = 3'b001;
      EXP_SRC1: oh = 3'b010;
      EXP_SRC2: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/exp_edge_sync.sv
// Multi-flop synchronizer followed by a rising-edge detector for one raw source.
module exp_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the raw level through the synchronizer and remember the last synced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], src_async};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Driven only by flops, so it is safe to use as a single-cycle event.
  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/exp_request_arbiter.sv
// Latches edge-detected exception sources and grants them one at a time to CP0,
// holding off further grants until the handler executes eret.
module exp_request_arbiter
  import exp_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  src_req,
  input  logic [NUM_SRC-1:0]  mask,
  input  logic                exp_block,
  input  logic                eret,
  output logic                has_exp,
  output logic [1:0]          exp_code,
  output logic [31:0]         exp_vector,
  output logic                in_service,
  output logic [NUM_SRC-1:0]  pending,
  output logic [NUM_SRC-1:0]  lost
);

  // Handler address for a code; code 0 wraps to one stride below the base.
  function automatic logic [31:0] vec_of(input logic [1:0] code);
    return VEC_BASE + (({30'd0, code}) - 32'd1) * VEC_STRIDE;
  endfunction

  exp_state_e         state_r, state_nxt_s;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] elig_s;
  logic [NUM_SRC-1:0] grant_onehot_s;
  logic [NUM_SRC-1:0] pending_r, pending_nxt_s;
  logic [NUM_SRC-1:0] lost_r, lost_nxt_s;
  logic               has_exp_r, has_exp_nxt_s;
  logic               in_service_r, in_service_nxt_s;
  logic [1:0]         exp_code_r, exp_code_nxt_s;
  logic [31:0]        exp_vector_r, exp_vector_nxt_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    exp_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
      .clk       (clk),
      .reset     (reset),
      .src_async (src_req[g]),
      .rise      (rise_s[g])
    );
  end

  assign elig_s = pending_r & mask;

  // Next state and next registered outputs of the grant/service sequence.
  always_comb begin
    state_nxt_s      = state_r;
    has_exp_nxt_s    = 1'b0;
    in_service_nxt_s = in_service_r;
    exp_code_nxt_s   = exp_code_r;
    exp_vector_nxt_s = exp_vector_r;
    grant_onehot_s   = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if ((|elig_s) && !exp_block) begin
          state_nxt_s      = ST_GRANT;
          has_exp_nxt_s    = 1'b1;
          in_service_nxt_s = 1'b1;
          exp_code_nxt_s   = prio_code(elig_s);
          exp_vector_nxt_s = vec_of(prio_code(elig_s));
          grant_onehot_s   = code_onehot(prio_code(elig_s));
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_nxt_s = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) begin
          state_nxt_s      = ST_RETURN;
          in_service_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      ST_RETURN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        in_service_nxt_s = 1'b0;
      end
    endcase
  end

  // Granted bit is cleared first so a same-cycle edge on it re-arms it.
  always_comb begin
    pending_nxt_s = (pending_r & ~grant_onehot_s) | rise_s;
    lost_nxt_s    = lost_r | (rise_s & pending_r & ~grant_onehot_s);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs and request bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_exp_r    <= 1'b0;
      in_service_r <= 1'b0;
      exp_code_r   <= EXP_NONE;
      exp_vector_r <= vec_of(EXP_NONE);
      pending_r    <= 3'b000;
      lost_r       <= 3'b000;
    end else begin
      has_exp_r    <= has_exp_nxt_s;
      in_service_r <= in_service_nxt_s;
      exp_code_r   <= exp_code_nxt_s;
      exp_vector_r <= exp_vector_nxt_s;
      pending_r    <= pending_nxt_s;
      lost_r       <= lost_nxt_s;
    end
  end

  assign has_exp    = has_exp_r;
  assign in_service = in_service_r;
  assign exp_code   = exp_code_r;
  assign exp_vector = exp_vector_r;
  assign pending    = pending_r;
  assign lost       = lost_r;

endmodule

// File: tb/tb_exp_request_arbiter.sv
// Directed-vector bench for exp_request_arbiter with default parameters.
module tb_exp_request_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  src_req;
  logic [2:0]  mask;
  logic        exp_block;
  logic        eret;
  logic        has_exp;
  logic [1:0]  exp_code;
  logic [31:0] exp_vector;
  logic        in_service;
  logic [2:0]  pending;
  logic [2:0]  lost;

  int errors = 0;
  int checks = 0;

  exp_request_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .src_req    (src_req),
    .mask       (mask),
    .exp_block  (exp_block),
    .eret       (eret),
    .has_exp    (has_exp),
    .exp_code   (exp_code),
    .exp_vector (exp_vector),
    .in_service (in_service),
    .pending    (pending),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // In SERVICE: pulse eret, then expect the next grant two edges after RETURN.
  task automatic grant_after_eret(input string name, input logic [1:0] code, input logic [31:0] vec);
    eret = 1'b1;
    step();
    check_bit({name, "_insvc_clr"}, in_service, 1'b0);
    eret = 1'b0;
    step();
    check_bit({name, "_no_grant_in_return"}, has_exp, 1'b0);
    step();
    check_bit({name, "_has_exp"}, has_exp, 1'b1);
    check_vec({name, "_code"}, {30'd0, exp_code}, {30'd0, code});
    check_vec({name, "_vec"}, exp_vector, vec);
    step();
    check_bit({name, "_pulse_end"}, has_exp, 1'b0);
  endtask

  task automatic end_service();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
  endtask

  task automatic settle_low();
    src_req = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; src_req = 3'b000; mask = 3'b111; exp_block = 1'b0; eret = 1'b0;
    #3;
    check_bit("rst_has_exp", has_exp, 1'b0);
    check_vec("rst_code", {30'd0, exp_code}, 32'd0);
    check_vec("rst_vec", exp_vector, 32'h0000_07F0);
    check_bit("rst_insvc", in_service, 1'b0);
    check_vec("rst_pending", {29'd0, pending}, 32'd0);
    check_vec("rst_lost", {29'd0, lost}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single();
    src_req = 3'b010;
    step(); step();
    check_vec("single_pend_E1", {29'd0, pending}, 32'd0);
    step();
    check_vec("single_pend_E2", {29'd0, pending}, 32'b010);
    check_bit("single_nogrant_E2", has_exp, 1'b0);
    step();
    check_bit("single_has_exp_E3", has_exp, 1'b1);
    check_vec("single_code", {30'd0, exp_code}, 32'd2);
    check_vec("single_vec", exp_vector, 32'h0000_0810);
    check_bit("single_insvc", in_service, 1'b1);
    check_vec("single_pend_clr", {29'd0, pending}, 32'd0);
    step();
    check_bit("single_pulse_end", has_exp, 1'b0);
    step();
    check_bit("single_insvc_hold", in_service, 1'b1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check_bit("single_insvc_clr", in_service, 1'b0);
    step();
    settle_low();
  endtask

  task automatic test_simultaneous();
    src_req = 3'b111;
    repeat (3) step();
    check_vec("simul_pend", {29'd0, pending}, 32'b111);
    step();
    check_bit("simul_g1", has_exp, 1'b1);
    check_vec("simul_g1_code", {30'd0, exp_code}, 32'd3);
    check_vec("simul_g1_vec", exp_vector, 32'h0000_0820);
    check_vec("simul_g1_pend", {29'd0, pending}, 32'b011);
    repeat (3) step();
    check_bit("simul_wait_eret", has_exp, 1'b0);
    grant_after_eret("simul_g2", 2'd2, 32'h0000_0810);
    grant_after_eret("simul_g3", 2'd1, 32'h0000_0800);
    end_service();
    settle_low();
    check_vec("simul_pend_empty", {29'd0, pending}, 32'd0);
    check_vec("simul_no_lost", {29'd0, lost}, 32'd0);
  endtask

  task automatic test_blocking();
    logic found;
    exp_block = 1'b1;
    src_req = 3'b001;
    repeat (6) step();
    check_vec("block_pend", {29'd0, pending}, 32'b001);
    check_bit("block_no_grant", has_exp, 1'b0);
    check_bit("block_no_svc", in_service, 1'b0);
    exp_block = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (has_exp === 1'b1) found = 1'b1;
    end
    check_bit("block_release_grant", found, 1'b1);
    check_vec("block_code", {30'd0, exp_code}, 32'd1);
    step();
    end_service();
    settle_low();
  endtask

  task automatic test_mask_lost();
    logic found;
    logic seen;
    mask = 3'b110;
    seen = 1'b0;
    src_req = 3'b001;
    for (int i = 0; i < 3; i++) begin step(); if (has_exp === 1'b1) seen = 1'b1; end
    src_req = 3'b000;
    for (int i = 0; i < 3; i++) begin step(); if (has_exp === 1'b1) seen = 1'b1; end
    check_vec("mask_pend_once", {29'd0, pending}, 32'b001);
    check_vec("mask_lost_before", {29'd0, lost}, 32'd0);
    src_req = 3'b001;
    for (int i = 0; i < 4; i++) begin step(); if (has_exp === 1'b1) seen = 1'b1; end
    check_bit("mask_no_grant", seen, 1'b0);
    check_vec("mask_pend_twice", {29'd0, pending}, 32'b001);
    check_vec("mask_lost_set", {29'd0, lost}, 32'b001);
    mask = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (has_exp === 1'b1) found = 1'b1;
    end
    check_bit("mask_unmask_grant", found, 1'b1);
    check_vec("mask_code", {30'd0, exp_code}, 32'd1);
    step();
    end_service();
    settle_low();
    check_vec("mask_lost_sticky", {29'd0, lost}, 32'b001);
  endtask

  task automatic test_rearm_collision();
    src_req = 3'b100;
    repeat (4) step();
    check_bit("rearm_g1", has_exp, 1'b1);
    check_vec("rearm_g1_code", {30'd0, exp_code}, 32'd3);
    step();
    settle_low();
    src_req = 3'b100;
    repeat (3) step();
    check_vec("rearm_pend_self", {29'd0, pending}, 32'b100);
    check_bit("rearm_still_svc", in_service, 1'b1);
    check_bit("rearm_no_grant", has_exp, 1'b0);
    src_req = 3'b110;
    step(); step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    check_vec("coll_pend_both", {29'd0, pending}, 32'b110);
    check_bit("coll_insvc_clr", in_service, 1'b0);
    check_vec("coll_lost_unchanged", {29'd0, lost}, 32'b001);
    step();
    check_bit("coll_no_grant_return", has_exp, 1'b0);
    step();
    check_bit("coll_g2", has_exp, 1'b1);
    check_vec("coll_g2_code", {30'd0, exp_code}, 32'd3);
    step();
    grant_after_eret("coll_g3", 2'd2, 32'h0000_0810);
    end_service();
    settle_low();
  endtask

  task automatic test_async_reset();
    logic seen;
    src_req = 3'b001;
    repeat (4) step();
    check_bit("areset_pre_grant", has_exp, 1'b1);
    step();
    check_bit("areset_pre_svc", in_service, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_bit("areset_has_exp", has_exp, 1'b0);
    check_vec("areset_code", {30'd0, exp_code}, 32'd0);
    check_vec("areset_vec", exp_vector, 32'h0000_07F0);
    check_bit("areset_insvc", in_service, 1'b0);
    check_vec("areset_pend", {29'd0, pending}, 32'd0);
    check_vec("areset_lost", {29'd0, lost}, 32'd0);
    src_req = 3'b000;
    step(); step();
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (has_exp === 1'b1) seen = 1'b1;
    end
    check_bit("areset_no_grant_after", seen, 1'b0);
    check_vec("areset_pend_after", {29'd0, pending}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_blocking();
    test_mask_lost();
    test_rearm_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
